// File: rtl/gato_move_ctrl.sv
// Gato (tic-tac-toe) move controller: owns the 3x3 board, arbitrates turns,
// validates and writes moves, evaluates win/tie and the optional turn timeout.
module gato_move_ctrl #(
  parameter int unsigned TIMEOUT   = 0,   // cycles per turn before forfeit, 0 = off
  parameter int unsigned TO_W      = 16,  // timeout counter width
  parameter int unsigned ALT_START = 1    // 1 = starter alternates on new_game
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        p1_req,
  input  logic [3:0]  p1_pos,
  input  logic        p2_req,
  input  logic [3:0]  p2_pos,
  output logic [17:0] board,
  output logic        turno_p1,
  output logic        turno_p2,
  output logic        p1_mm,
  output logic        p2_mm,
  output logic        p1_err,
  output logic        p2_err,
  output logic        p1_win,
  output logic        p1_loss,
  output logic        p1_tie,
  output logic        p2_win,
  output logic        p2_loss,
  output logic        p2_tie,
  output logic        game_over,
  output logic [3:0]  move_cnt
);

  typedef enum logic [1:0] {StP1, StP2, StChk, StEnd} state_e;

  state_e          state_q;
  logic [17:0]     board_q;
  logic [3:0]      move_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            last_p2_q;   // last accepted mover was P2
  logic            start_p2_q;  // current game was started by P2
  logic            new_game_q;  // for rising-edge detection of new_game
  logic            p1_mm_q, p2_mm_q, p1_err_q, p2_err_q;
  logic            p1_win_q, p1_loss_q, p1_tie_q, p2_win_q, p2_loss_q, p2_tie_q;

  logic [31:0]     board_ext;
  logic [1:0]      cell_p1, cell_p2;
  logic            cur_req, cur_ok;
  logic [3:0]      cur_pos;
  logic [1:0]      cur_mark;
  logic [17:0]     board_wr;
  logic            timeout_hit;
  logic            line_done;
  logic            ng_rise;
  logic            start_sel;

  // True when any of the 8 lines is fully owned by mark m.
  function automatic logic line_win(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int i = 0; i < 9; i++) own[i] = (b[2*i +: 2] == m);
    return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  endfunction

  // Zero-extended board so out-of-range positions index harmlessly.
  assign board_ext = {14'd0, board_q};
  assign cell_p1   = board_ext[{p1_pos, 1'b0} +: 2];
  assign cell_p2   = board_ext[{p2_pos, 1'b0} +: 2];

  // Select the on-turn player's request and validate it.
  always_comb begin
    cur_req  = p1_req;
    cur_pos  = p1_pos;
    cur_mark = 2'b01;
    cur_ok   = (p1_pos <= 4'd8) && (cell_p1 == 2'b00);
    if (state_q == StP2) begin
      cur_req  = p2_req;
      cur_pos  = p2_pos;
      cur_mark = 2'b10;
      cur_ok   = (p2_pos <= 4'd8) && (cell_p2 == 2'b00);
    end
  end

  // Board image with the current move written in.
  always_comb begin
    board_wr = board_q;
    for (int i = 0; i < 9; i++) begin
      if (cur_pos == 4'(i)) board_wr[2*i +: 2] = cur_mark;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign line_done   = line_win(board_q, last_p2_q ? 2'b10 : 2'b01);
  assign ng_rise     = new_game & ~new_game_q;
  // Starter only flips on the rising edge; a held new_game keeps restarting the same game.
  assign start_sel   = ng_rise ? ((ALT_START != 0) ? ~start_p2_q : 1'b0) : start_p2_q;

  // Game FSM with board, counters and registered pulses/results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StP1;
      board_q    <= '0;
      move_cnt_q <= '0;
      to_cnt_q   <= '0;
      last_p2_q  <= 1'b0;
      start_p2_q <= 1'b0;
      new_game_q <= 1'b0;
      p1_mm_q    <= 1'b0;
      p2_mm_q    <= 1'b0;
      p1_err_q   <= 1'b0;
      p2_err_q   <= 1'b0;
      p1_win_q   <= 1'b0;
      p1_loss_q  <= 1'b0;
      p1_tie_q   <= 1'b0;
      p2_win_q   <= 1'b0;
      p2_loss_q  <= 1'b0;
      p2_tie_q   <= 1'b0;
    end else begin
      new_game_q <= new_game;
      p1_mm_q    <= 1'b0;
      p2_mm_q    <= 1'b0;
      p1_err_q   <= 1'b0;
      p2_err_q   <= 1'b0;
      if (new_game) begin
        board_q    <= '0;
        move_cnt_q <= '0;
        to_cnt_q   <= '0;
        last_p2_q  <= 1'b0;
        start_p2_q <= start_sel;
        state_q    <= start_sel ? StP2 : StP1;
        p1_win_q   <= 1'b0;
        p1_loss_q  <= 1'b0;
        p1_tie_q   <= 1'b0;
        p2_win_q   <= 1'b0;
        p2_loss_q  <= 1'b0;
        p2_tie_q   <= 1'b0;
      end else begin
        case (state_q)
          StP1, StP2: begin
            if (cur_req && cur_ok) begin
              // Accepted move beats a simultaneous timeout expiry.
              board_q    <= board_wr;
              move_cnt_q <= move_cnt_q + 4'd1;
              last_p2_q  <= (state_q == StP2);
              p1_mm_q    <= (state_q == StP1);
              p2_mm_q    <= (state_q == StP2);
              to_cnt_q   <= '0;
              state_q    <= StChk;
            end else begin
              if (cur_req) begin
                p1_err_q <= (state_q == StP1);
                p2_err_q <= (state_q == StP2);
              end
              if (timeout_hit) begin
                p1_loss_q <= (state_q == StP1);
                p2_win_q  <= (state_q == StP1);
                p2_loss_q <= (state_q == StP2);
                p1_win_q  <= (state_q == StP2);
                state_q   <= StEnd;
              end else if (TIMEOUT != 0) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
              end
            end
          end
          StChk: begin
            to_cnt_q <= '0;
            if (line_done) begin
              p1_win_q  <= ~last_p2_q;
              p2_loss_q <= ~last_p2_q;
              p2_win_q  <= last_p2_q;
              p1_loss_q <= last_p2_q;
              state_q   <= StEnd;
            end else if (move_cnt_q == 4'd9) begin
              p1_tie_q <= 1'b1;
              p2_tie_q <= 1'b1;
              state_q  <= StEnd;
            end else begin
              state_q <= last_p2_q ? StP1 : StP2;
            end
          end
          default: ;  // StEnd: hold everything until new_game
        endcase
      end
    end
  end

  assign board     = board_q;
  assign move_cnt  = move_cnt_q;
  assign turno_p1  = (state_q == StP1);
  assign turno_p2  = (state_q == StP2);
  assign game_over = (state_q == StEnd);
  assign p1_mm     = p1_mm_q;
  assign p2_mm     = p2_mm_q;
  assign p1_err    = p1_err_q;
  assign p2_err    = p2_err_q;
  assign p1_win    = p1_win_q;
  assign p1_loss   = p1_loss_q;
  assign p1_tie    = p1_tie_q;
  assign p2_win    = p2_win_q;
  assign p2_loss   = p2_loss_q;
  assign p2_tie    = p2_tie_q;

endmodule

// File: tb/tb_gato_move_ctrl.sv
// Directed bench for gato_move_ctrl: a default instance (no timeout, alternating
// starter) and a second instance with a 20-cycle turn timeout.
module tb_gato_move_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic new_game, p1_req, p2_req;
  logic [3:0] p1_pos, p2_pos;
  logic [17:0] board;
  logic turno_p1, turno_p2, p1_mm, p2_mm, p1_err, p2_err;
  logic p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie, game_over;
  logic [3:0] move_cnt;

  // Timeout instance signals
  logic t_new_game, t_p1_req, t_p2_req;
  logic [3:0] t_p1_pos, t_p2_pos;
  logic [17:0] t_board;
  logic t_turno_p1, t_turno_p2, t_p1_mm, t_p2_mm, t_p1_err, t_p2_err;
  logic t_p1_win, t_p1_loss, t_p1_tie, t_p2_win, t_p2_loss, t_p2_tie, t_game_over;
  logic [3:0] t_move_cnt;

  int cmps = 0;
  int errs = 0;

  gato_move_ctrl dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .p1_req(p1_req), .p1_pos(p1_pos), .p2_req(p2_req), .p2_pos(p2_pos),
    .board(board), .turno_p1(turno_p1), .turno_p2(turno_p2),
    .p1_mm(p1_mm), .p2_mm(p2_mm), .p1_err(p1_err), .p2_err(p2_err),
    .p1_win(p1_win), .p1_loss(p1_loss), .p1_tie(p1_tie),
    .p2_win(p2_win), .p2_loss(p2_loss), .p2_tie(p2_tie),
    .game_over(game_over), .move_cnt(move_cnt)
  );

  gato_move_ctrl #(.TIMEOUT(20), .TO_W(16), .ALT_START(1)) dut_to (
    .clk(clk), .reset(reset), .new_game(t_new_game),
    .p1_req(t_p1_req), .p1_pos(t_p1_pos), .p2_req(t_p2_req), .p2_pos(t_p2_pos),
    .board(t_board), .turno_p1(t_turno_p1), .turno_p2(t_turno_p2),
    .p1_mm(t_p1_mm), .p2_mm(t_p2_mm), .p1_err(t_p1_err), .p2_err(t_p2_err),
    .p1_win(t_p1_win), .p1_loss(t_p1_loss), .p1_tie(t_p1_tie),
    .p2_win(t_p2_win), .p2_loss(t_p2_loss), .p2_tie(t_p2_tie),
    .game_over(t_game_over), .move_cnt(t_move_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    new_game = 0; p1_req = 0; p2_req = 0; p1_pos = 0; p2_pos = 0;
    t_new_game = 0; t_p1_req = 0; t_p2_req = 0; t_p1_pos = 0; t_p2_pos = 0;
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  // Full turn: request, S_CHK cycle, next state visible.
  task automatic mv1(input logic [3:0] pos);
    p1_req = 1; p1_pos = pos; step(); p1_req = 0; step();
  endtask

  task automatic mv2(input logic [3:0] pos);
    p2_req = 1; p2_pos = pos; step(); p2_req = 0; step();
  endtask

  task automatic test_reset();
    apply_reset();
    cmps++; if (board !== 18'h0) begin errs++; $display("FAIL rst_board got %h want %h", board, 18'h0); end
    cmps++; if (move_cnt !== 4'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", move_cnt); end
    cmps++; if ({turno_p1, turno_p2} !== 2'b10) begin errs++; $display("FAIL rst_turno got %b want 10", {turno_p1, turno_p2}); end
    cmps++; if ({p1_mm, p2_mm, p1_err, p2_err, p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie, game_over} !== 11'b0) begin
      errs++; $display("FAIL rst_flags got %b want 0", {p1_mm, p2_mm, p1_err, p2_err, p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie, game_over}); end
  endtask

  task automatic test_win();
    apply_reset();
    p1_req = 1; p1_pos = 0; step(); p1_req = 0;
    cmps++; if (p1_mm !== 1'b1 || board !== 18'h00001) begin errs++; $display("FAIL win_first_mm got mm=%b board=%h want mm=1 board=00001", p1_mm, board); end
    cmps++; if ({turno_p1, turno_p2} !== 2'b00) begin errs++; $display("FAIL win_chk_turno got %b want 00", {turno_p1, turno_p2}); end
    step();
    cmps++; if (turno_p2 !== 1'b1 || p1_mm !== 1'b0) begin errs++; $display("FAIL win_turn2 got turno_p2=%b mm=%b want 1,0", turno_p2, p1_mm); end
    mv2(3); mv1(1); mv2(4); mv1(2);
    cmps++; if (board !== 18'h00295) begin errs++; $display("FAIL win_board got %h want %h", board, 18'h00295); end
    cmps++; if (move_cnt !== 4'd5) begin errs++; $display("FAIL win_cnt got %0d want 5", move_cnt); end
    cmps++; if ({p1_win, p2_loss, game_over} !== 3'b111) begin errs++; $display("FAIL win_res got %b want 111", {p1_win, p2_loss, game_over}); end
    cmps++; if ({p1_loss, p1_tie, p2_win, p2_tie, turno_p1, turno_p2} !== 6'b0) begin errs++; $display("FAIL win_others got %b want 0", {p1_loss, p1_tie, p2_win, p2_tie, turno_p1, turno_p2}); end
    p2_req = 1; p2_pos = 5; step(); p2_req = 0;
    cmps++; if (p2_err !== 1'b0 || p2_mm !== 1'b0 || board !== 18'h00295) begin errs++; $display("FAIL end_ignore got err=%b mm=%b board=%h want 0,0,00295", p2_err, p2_mm, board); end
    cmps++; if (p1_win !== 1'b1 || game_over !== 1'b1) begin errs++; $display("FAIL end_hold got win=%b go=%b want 1,1", p1_win, game_over); end
  endtask

  task automatic test_reject();
    apply_reset();
    mv1(4);
    p2_req = 1; p2_pos = 4; step(); p2_req = 0;
    cmps++; if (p2_err !== 1'b1 || p2_mm !== 1'b0) begin errs++; $display("FAIL rej_occ got err=%b mm=%b want 1,0", p2_err, p2_mm); end
    cmps++; if (board[9:8] !== 2'b01 || turno_p2 !== 1'b1) begin errs++; $display("FAIL rej_occ_hold got cell4=%b turno_p2=%b want 01,1", board[9:8], turno_p2); end
    step();
    cmps++; if (p2_err !== 1'b0) begin errs++; $display("FAIL rej_pulse got %b want 0", p2_err); end
    p2_req = 1; p2_pos = 9; step(); p2_req = 0;
    cmps++; if (p2_err !== 1'b1 || board !== 18'h00100) begin errs++; $display("FAIL rej_range got err=%b board=%h want 1,00100", p2_err, board); end
    p2_req = 1; p2_pos = 0; step(); p2_req = 0;
    cmps++; if (p2_mm !== 1'b1 || p2_err !== 1'b0 || board[1:0] !== 2'b10) begin errs++; $display("FAIL rej_then_ok got mm=%b err=%b cell0=%b want 1,0,10", p2_mm, p2_err, board[1:0]); end
    step();
    cmps++; if (turno_p1 !== 1'b1 || move_cnt !== 4'd2) begin errs++; $display("FAIL rej_next got turno_p1=%b cnt=%0d want 1,2", turno_p1, move_cnt); end
  endtask

  task automatic test_tie();
    apply_reset();
    mv1(0);
    p1_req = 1; p1_pos = 5; step(); p1_req = 0;
    cmps++; if (p1_err !== 1'b0 || p1_mm !== 1'b0 || board !== 18'h00001 || turno_p2 !== 1'b1) begin
      errs++; $display("FAIL offturn got err=%b mm=%b board=%h turno_p2=%b want 0,0,00001,1", p1_err, p1_mm, board, turno_p2); end
    mv2(1); mv1(2); mv2(4); mv1(3); mv2(5); mv1(7); mv2(6); mv1(8);
    cmps++; if (board !== 18'h16A59) begin errs++; $display("FAIL tie_board got %h want %h", board, 18'h16A59); end
    cmps++; if (move_cnt !== 4'd9) begin errs++; $display("FAIL tie_cnt got %0d want 9", move_cnt); end
    cmps++; if ({p1_tie, p2_tie, game_over} !== 3'b111) begin errs++; $display("FAIL tie_res got %b want 111", {p1_tie, p2_tie, game_over}); end
    cmps++; if ({p1_win, p2_win, p1_loss, p2_loss} !== 4'b0) begin errs++; $display("FAIL tie_nowin got %b want 0000", {p1_win, p2_win, p1_loss, p2_loss}); end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 19; i++) step();
    cmps++; if (t_game_over !== 1'b0 || t_turno_p1 !== 1'b1) begin errs++; $display("FAIL to_early got go=%b turno=%b want 0,1", t_game_over, t_turno_p1); end
    step();
    cmps++; if ({t_p1_loss, t_p2_win, t_game_over} !== 3'b111) begin errs++; $display("FAIL to_expire got %b want 111", {t_p1_loss, t_p2_win, t_game_over}); end
    cmps++; if ({t_p1_win, t_p2_loss, t_turno_p1} !== 3'b000) begin errs++; $display("FAIL to_others got %b want 000", {t_p1_win, t_p2_loss, t_turno_p1}); end
    apply_reset();
    for (int i = 0; i < 19; i++) step();
    t_p1_req = 1; t_p1_pos = 0; step(); t_p1_req = 0;
    cmps++; if (t_p1_mm !== 1'b1 || t_p1_loss !== 1'b0 || t_game_over !== 1'b0) begin
      errs++; $display("FAIL to_race got mm=%b loss=%b go=%b want 1,0,0", t_p1_mm, t_p1_loss, t_game_over); end
    step();
    cmps++; if (t_turno_p2 !== 1'b1 || t_board !== 18'h00001) begin errs++; $display("FAIL to_race_next got turno_p2=%b board=%h want 1,00001", t_turno_p2, t_board); end
  endtask

  task automatic test_new_game();
    apply_reset();
    mv1(0); mv2(1); mv1(4);
    cmps++; if (move_cnt !== 4'd3 || turno_p2 !== 1'b1) begin errs++; $display("FAIL ng_pre got cnt=%0d turno_p2=%b want 3,1", move_cnt, turno_p2); end
    new_game = 1; step(); new_game = 0;
    cmps++; if (board !== 18'h0 || move_cnt !== 4'd0) begin errs++; $display("FAIL ng_clear got board=%h cnt=%0d want 0,0", board, move_cnt); end
    cmps++; if ({turno_p1, turno_p2} !== 2'b01) begin errs++; $display("FAIL ng_start_p2 got %b want 01", {turno_p1, turno_p2}); end
    step();
    new_game = 1; step(); new_game = 0;
    cmps++; if ({turno_p1, turno_p2} !== 2'b10) begin errs++; $display("FAIL ng_start_p1 got %b want 10", {turno_p1, turno_p2}); end
    step();
    new_game = 1; p1_req = 1; p1_pos = 0; step(); new_game = 0; p1_req = 0;
    cmps++; if (board !== 18'h0 || p1_mm !== 1'b0 || move_cnt !== 4'd0) begin errs++; $display("FAIL ng_drop got board=%h mm=%b cnt=%0d want 0,0,0", board, p1_mm, move_cnt); end
    cmps++; if (turno_p2 !== 1'b1) begin errs++; $display("FAIL ng_drop_turn got %b want 1", turno_p2); end
    step();
    new_game = 1; step(); step(); step(); new_game = 0;
    cmps++; if ({turno_p1, turno_p2} !== 2'b10) begin errs++; $display("FAIL ng_held got %b want 10", {turno_p1, turno_p2}); end
  endtask

  task automatic test_reset_mid_chk();
    apply_reset();
    mv1(0); mv2(3); mv1(1); mv2(4);
    p1_req = 1; p1_pos = 2; step(); p1_req = 0;
    cmps++; if (p1_mm !== 1'b1 || turno_p1 !== 1'b0) begin errs++; $display("FAIL rmid_in_chk got mm=%b turno=%b want 1,0", p1_mm, turno_p1); end
    #2 reset = 0;
    #1;
    cmps++; if (board !== 18'h0 || move_cnt !== 4'd0 || p1_mm !== 1'b0) begin errs++; $display("FAIL rmid_async got board=%h cnt=%0d mm=%b want 0,0,0", board, move_cnt, p1_mm); end
    cmps++; if (p1_win !== 1'b0 || turno_p1 !== 1'b1 || game_over !== 1'b0) begin errs++; $display("FAIL rmid_flags got win=%b turno=%b go=%b want 0,1,0", p1_win, turno_p1, game_over); end
    step(); step();
    reset = 1;
    step();
    cmps++; if (turno_p1 !== 1'b1 || p1_win !== 1'b0 || p2_loss !== 1'b0) begin errs++; $display("FAIL rmid_release got turno=%b win=%b loss=%b want 1,0,0", turno_p1, p1_win, p2_loss); end
  endtask

  initial begin
    test_reset();
    test_win();
    test_reject();
    test_tie();
    test_timeout();
    test_new_game();
    test_reset_mid_chk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
